mc_datapath: RTL
================

# mc_datapath

Multicycle RV32I-subset datapath that executes one instruction over several states and shares ALU and register-file work across cycles. Instruction and data memories connect through valid/ready request handshakes, so they may insert wait states. It sits between the top-level CPU wrapper and the ROM/RAM models. Illegal or misaligned operations halt the core cleanly instead of corrupting state.

## Interface
- INITIAL_PC, 32'h00400000, PC value loaded on reset.
- NREGS, 32, register count (power of 2, at most 32); rs/rd indices ≥ NREGS read 0, and writes to them are dropped.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; high only in FETCH and while rst=0.
- imem_addr  out  32  equals pc.
- imem_ready  in  1  fetch done this cycle; imem_rdata valid.
- imem_rdata  in  32  instruction word.
- dmem_req  out  1  data request; high only in MEM.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req=1.
- dmem_addr  out  32  ALU result (rs1 + imm).
- dmem_wdata  out  32  rs2 value latched in DECODE.
- dmem_ready  in  1  data access done this cycle.
- dmem_rdata  in  32  load data; valid when dmem_ready=1.
- pc  out  32  address of the current instruction.
- retire  out  1  one-cycle pulse on the final cycle of each completed instruction.
- halted  out  1  high in TRAP.

## Operation
- FSM states: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: hold imem_req until imem_ready=1. On that edge, latch IR=imem_rdata and go to DECODE.
- DECODE: latch A=x[rs1] and B=x[rs2]. Latch imm, selected by opcode: I {{20{i31}},i31:20}, S {{20{i31}},i31:25,i11:7}, B {{19{i31}},i31,i7,i30:25,i11:8,0}. An unsupported opcode or funct goes to TRAP.
- Supported instructions:
  - R (0110011): add, sub, sll, slt, sltu, xor, srl, sra, or, and.
  - I (0010011): the same set without sub; shift amount is imm[4:0]; srai is selected by i30.
  - lw (0000011, f3=010).
  - sw (0100011, f3=010).
  - beq/bne (1100011, f3=000/001).
- EXEC:
  - R/I: ALUOut=A op (B or imm), then go to WB.
  - lw/sw: ALUOut=A+imm. If ALUOut[1:0]≠0, go to TRAP; otherwise go to MEM.
  - Branch: compare A with B. If taken, target=pc+imm; if target[1:0]≠0, go to TRAP. Otherwise pc←taken ? target : pc+4, pulse retire, go to FETCH.
- MEM: hold dmem_req until dmem_ready=1.
  - Store: on that edge, pc←pc+4, pulse retire, go to FETCH.
  - Load: latch MDR=dmem_rdata, go to WB.
- WB: x[rd]←(load ? MDR : ALUOut) unless rd=0. Then pc←pc+4, pulse retire, go to FETCH.
- Register x0 always reads 0.
- TRAP: terminal state. pc holds the faulting instruction's address, no memory requests, no register writes, retire=0. Only rst exits TRAP.
- Arithmetic is modulo 2^32. slt is signed; sltu is unsigned. sra is arithmetic. pc+imm wraps.

## Timing
- Reset values: pc=INITIAL_PC, state=FETCH, all registers 0, IR/A/B/ALUOut/MDR=0. imem_req and dmem_req are 0 while rst=1. retire=0, halted=0.
- The first imem_req is asserted in the first cycle with rst=0.
- imem_ready/dmem_ready are sampled on the same cycle as the request; zero-wait memories complete in one cycle.
- Request outputs stay stable while waiting. A ready received while the corresponding req=0 is ignored.
- Cycles per instruction with zero wait states: branch 3, R/I 4, sw 4, lw 5. Each memory wait state adds 1.
- Register write and pc update take effect on the same edge. The next DECODE sees the new register value, so no forwarding is needed.
- rst asserted mid-instruction aborts it on the next edge: no register write, requests drop immediately, and the in-flight memory transaction is abandoned.

## Test plan
- **Reset:** hold rst 2 cycles, release. Required: imem_addr=0x00400000, imem_req=1 on the first free cycle, halted=0.
- **addi then add:** zero-wait memory. Run addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2. Required: x3=2, 3 retire pulses in 12 cycles, pc=0x0040000C.
- **Store then load with wait states:** sw x1,8(x0) then lw x4,8(x0), with dmem_ready delayed by 3 cycles. Required: dmem_addr=8, dmem_we=1 then 0, dmem_wdata stable during the wait, x4=5. The lw takes 8 cycles.
- **Branches:** beq x1,x1,-8 at 0x00400010. Required: pc=0x00400008 after 3 cycles. bne x1,x1,+16 not taken: pc+4.
- **x0 and shifts:** addi x0,x0,7 leaves x0=0. srai of 0x80000000 by 4 gives 0xF8000000; srli of the same gives 0x08000000.
- **Traps:** lw x5,2(x0) goes to TRAP with halted=1, pc unchanged, no dmem_req. Opcode 0x7F also traps. rst recovers the core to INITIAL_PC.

Source files
------------

// File: rtl/mc_datapath.sv
// Multicycle RV32I-subset datapath: one instruction spread over FETCH/DECODE/EXEC/MEM/WB,
// with valid/ready memory handshakes and a terminal TRAP state for illegal or misaligned work.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_FETCH  | imem_req high until imem_ready, then latch IR
// S_DECODE | read rs1/rs2 into A/B, build immediate, reject unsupported encodings
// S_EXEC   | ALU op, address generation or branch resolution
// S_MEM    | dmem_req high until dmem_ready; store retires here
// S_WB     | register write, pc+4, retire
// S_TRAP   | halted; only rst leaves
module mc_datapath #(
  parameter logic [31:0] INITIAL_PC = 32'h0040_0000,
  parameter int          NREGS      = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] pc,
  output logic        retire,
  output logic        halted
);

  localparam int         AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [5:0] NREGS_L = 6'(NREGS);
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] imm_q, imm_d, alu_q, alu_d, mdr_q, mdr_d;
  logic [31:0] regs_q [NREGS];
  logic [31:0] regs_d [NREGS];

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2, shamt;
  logic [2:0]  f3;
  logic [31:0] rs1_val, rs2_val, op_b, alu_res, addr_sum, br_target;
  logic        alt, legal, br_taken, retire_c;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign f7     = ir_q[31:25];

  assign addr_sum  = a_q + imm_q;
  assign br_target = pc_q + imm_q;
  assign br_taken  = (a_q == b_q) ^ f3[0];

  // Register-file read ports; x0 and indices past NREGS read as zero.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0 && {1'b0, rs1} < NREGS_L) rs1_val = regs_q[rs1[AW-1:0]];
    if (rs2 != 5'd0 && {1'b0, rs2} < NREGS_L) rs2_val = regs_q[rs2[AW-1:0]];
  end

  // Encoding check: anything outside the supported subset traps from DECODE.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_R:  legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
      OP_I: begin
        case (f3)
          3'b001:  legal = (f7 == 7'h00);
          3'b101:  legal = (f7 == 7'h00) || (f7 == 7'h20);
          default: legal = 1'b1;
        endcase
      end
      OP_LW, OP_SW: legal = (f3 == 3'b010);
      OP_BR:        legal = (f3[2:1] == 2'b00);
      default:      legal = 1'b0;
    endcase
  end

  // Shared ALU; bit 30 picks sub/sra, but for op-imm only on the shift-right encoding.
  always_comb begin
    op_b    = (opcode == OP_R) ? b_q : imm_q;
    alt     = ir_q[30] && (opcode == OP_R || f3 == 3'b101);
    shamt   = op_b[4:0];
    alu_res = '0;
    case (f3)
      3'b000: alu_res = alt ? (a_q - op_b) : (a_q + op_b);
      3'b001: alu_res = a_q << shamt;
      3'b010: alu_res = {31'b0, $signed(a_q) < $signed(op_b)};
      3'b011: alu_res = {31'b0, a_q < op_b};
      3'b100: alu_res = a_q ^ op_b;
      3'b101: begin
        if (alt) alu_res = $signed(a_q) >>> shamt;
        else     alu_res = a_q >> shamt;
      end
      3'b110: alu_res = a_q | op_b;
      default: alu_res = a_q & op_b;
    endcase
  end

  // Next-state, datapath latches and retire for each FSM state.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    imm_d    = imm_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    regs_d   = regs_q;
    retire_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d = rs1_val;
        b_d = rs2_val;
        case (opcode)
          OP_SW:   imm_d = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
          OP_BR:   imm_d = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
          default: imm_d = {{20{ir_q[31]}}, ir_q[31:20]};
        endcase
        state_d = legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        case (opcode)
          OP_LW, OP_SW: begin
            alu_d   = addr_sum;
            state_d = (addr_sum[1:0] != 2'b00) ? S_TRAP : S_MEM;
          end
          OP_BR: begin
            if (br_taken && br_target[1:0] != 2'b00) begin
              state_d = S_TRAP;
            end else begin
              pc_d     = br_taken ? br_target : pc_q + 32'd4;
              retire_c = 1'b1;
              state_d  = S_FETCH;
            end
          end
          default: begin
            alu_d   = alu_res;
            state_d = S_WB;
          end
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (opcode == OP_SW) begin
            pc_d     = pc_q + 32'd4;
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end else begin
            mdr_d   = dmem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        if (rd != 5'd0 && {1'b0, rd} < NREGS_L)
          regs_d[rd[AW-1:0]] = (opcode == OP_LW) ? mdr_q : alu_q;
        pc_d     = pc_q + 32'd4;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_TRAP;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= INITIAL_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      regs_q  <= regs_d;
    end
  end

  // Requests drop combinationally with rst so an in-flight access is abandoned at once.
  assign imem_req   = (state_q == S_FETCH) && !rst;
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == S_MEM) && !rst;
  assign dmem_we    = (opcode == OP_SW);
  assign dmem_addr  = alu_q;
  assign dmem_wdata = b_q;
  assign pc         = pc_q;
  assign retire     = retire_c && !rst;
  assign halted     = (state_q == S_TRAP);

endmodule
